// File: rtl/wbus_pkg.sv
// Shared encodings and defaults for the write-bus scheduler.
package wbus_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ADDR = 2'b01,
      S_DATA = 2'b10,
      S_RESP = 2'b11
   } state_t;

   localparam logic [3:0] DEF_ID0     = 4'h1;
   localparam logic [3:0] DEF_ID1     = 4'h2;
   localparam int         DEF_TIMEOUT = 1024;

   // A disabled timeout still needs a 1-bit counter to keep the vector legal.
   function automatic int tmo_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on contention the requester that did not win last time goes.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);
   always_comb begin
      gnt_valid = |req;
      gnt_idx   = (req == 2'b11) ? ~last : req[1];
   end
endmodule

// File: rtl/wbus_wr_sched.sv
// Serialises dcache-writeback and I/O-store writes onto the shared write bus,
// one transaction in flight, with a response timeout.
module wbus_wr_sched
   import wbus_pkg::*;
#(
   parameter int         ADDR_W  = 32,
   parameter logic [3:0] ID0     = DEF_ID0,
   parameter logic [3:0] ID1     = DEF_ID1,
   parameter int         TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [7:0]        req0_len,
   output logic              req0_grant,
   output logic              req0_done,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [7:0]        req1_len,
   output logic              req1_grant,
   output logic              req1_done,
   output logic              req1_err,
   output logic              awvalid,
   input  logic              awready,
   output logic [ADDR_W-1:0] awaddr,
   output logic [7:0]        awlen,
   output logic [3:0]        awid,
   output logic              wd_start,
   output logic              wd_sel,
   input  logic              finish_wd,
   input  logic              finish_wresp,
   output logic              busy
);
   localparam int            TW       = tmo_width(TIMEOUT);
   localparam bit            TMO_EN   = (TIMEOUT > 0);
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            r_state, w_next;
   logic              r_last, r_owner;
   logic [ADDR_W-1:0] r_awaddr;
   logic [7:0]        r_awlen;
   logic [3:0]        r_awid;
   logic              r_wd_start, r_done0, r_done1, r_err0, r_err1;
   logic [TW-1:0]     r_tmo_cnt;

   logic w_gnt_valid, w_gnt_idx, w_sel, w_aw_hs, w_in_xfer, w_cmpl, w_expire, w_abort;

   rr_arb2 u_arb (
      .req       ({req1_valid, req0_valid}),
      .last      (r_last),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   // Arbitration waits out the done/err cycle so a requester can react before re-entry.
   assign w_sel     = (r_state == S_IDLE) & w_gnt_valid & ~(r_done0 | r_done1 | r_err0 | r_err1);
   assign w_aw_hs   = (r_state == S_ADDR) & awready;
   assign w_in_xfer = (r_state == S_DATA) | (r_state == S_RESP);
   assign w_cmpl    = ((r_state == S_RESP) & finish_wresp) |
                      ((r_state == S_DATA) & finish_wd & finish_wresp);
   assign w_expire  = TMO_EN & w_in_xfer & (r_tmo_cnt == TMO_LAST);
   assign w_abort   = w_expire & ~w_cmpl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_sel) w_next = S_ADDR;
         S_ADDR: if (awready) w_next = S_DATA;
         S_DATA: begin
            if (w_cmpl | w_abort) w_next = S_IDLE;
            else if (finish_wd)   w_next = S_RESP;
         end
         S_RESP: if (w_cmpl | w_abort) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last     <= 1'b1;
         r_owner    <= 1'b0;
         r_awaddr   <= '0;
         r_awlen    <= '0;
         r_awid     <= '0;
         r_wd_start <= 1'b0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_err0     <= 1'b0;
         r_err1     <= 1'b0;
         r_tmo_cnt  <= '0;
      end else begin
         if (w_sel) begin
            r_last   <= w_gnt_idx;
            r_owner  <= w_gnt_idx;
            r_awaddr <= w_gnt_idx ? req1_addr : req0_addr;
            r_awlen  <= w_gnt_idx ? req1_len : req0_len;
            r_awid   <= w_gnt_idx ? ID1 : ID0;
         end
         if (w_aw_hs)        r_tmo_cnt <= '0;
         else if (w_in_xfer) r_tmo_cnt <= r_tmo_cnt + 1'b1;
         r_wd_start <= w_aw_hs;
         r_done0    <= w_cmpl & ~r_owner;
         r_done1    <= w_cmpl & r_owner;
         r_err0     <= w_abort & ~r_owner;
         r_err1     <= w_abort & r_owner;
      end
   end

   always_comb begin
      awvalid    = (r_state == S_ADDR);
      req0_grant = w_aw_hs & ~r_owner;
      req1_grant = w_aw_hs & r_owner;
      busy       = (r_state != S_IDLE);
      awaddr     = r_awaddr;
      awlen      = r_awlen;
      awid       = r_awid;
      wd_sel     = r_owner;
      wd_start   = r_wd_start;
      req0_done  = r_done0;
      req1_done  = r_done1;
      req0_err   = r_err0;
      req1_err   = r_err1;
   end
endmodule

// File: tb/tb_wbus_wr_sched.sv
// Scenario bench for wbus_wr_sched: grant/done/err pulses are matched against a scoreboard.
module tb_wbus_wr_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 0, req1_valid = 0;
   logic [31:0] req0_addr = 0, req1_addr = 0;
   logic [7:0]  req0_len = 0, req1_len = 0;
   logic        req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err;
   logic        awvalid, awready = 0;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [3:0]  awid;
   logic        wd_start, wd_sel, busy;
   logic        finish_wd = 0, finish_wresp = 0;

   int checks = 0, failures = 0;

   typedef struct {int kind; int idx; logic [31:0] addr; logic [7:0] len;} ev_t; // kind 0 grant, 1 done, 2 err
   ev_t sb[$];

   always #5 clk = ~clk;

   wbus_wr_sched #(.ADDR_W(32), .ID0(4'h1), .ID1(4'h2), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len),
      .req0_grant(req0_grant), .req0_done(req0_done), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len),
      .req1_grant(req1_grant), .req1_done(req1_done), .req1_err(req1_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
      .wd_start(wd_start), .wd_sel(wd_sel), .finish_wd(finish_wd), .finish_wresp(finish_wresp),
      .busy(busy)
   );

   // Scoreboard monitor: every pulse must match the next expected event.
   always @(negedge clk) begin
      logic [5:0] p;
      ev_t        e;
      int         k, ix;
      logic [3:0] exp_id;
      p = {req1_err, req1_done, req1_grant, req0_err, req0_done, req0_grant};
      for (int b = 0; b < 6; b++) begin
         if (p[b] === 1'b1) begin
            k = b % 3; ix = b / 3;
            exp_id = (ix == 1) ? 4'h2 : 4'h1;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected kind=%0d idx=%0d, expected no event", k, ix);
            end else begin
               e = sb.pop_front();
               if (e.kind != k || e.idx != ix) begin
                  failures++;
                  $display("FAIL sb_order got kind=%0d idx=%0d exp kind=%0d idx=%0d", k, ix, e.kind, e.idx);
               end else if (k == 0 && (awaddr !== e.addr || awlen !== e.len || awid !== exp_id || wd_sel !== ix[0])) begin
                  failures++;
                  $display("FAIL sb_aw got addr=%h len=%0d id=%h sel=%b exp addr=%h len=%0d id=%h sel=%0d",
                           awaddr, awlen, awid, wd_sel, e.addr, e.len, exp_id, ix);
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic wait_aw(output bit got);
      got = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (awvalid === 1'b1) begin got = 1; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst = 1; tick; tick;
      @(negedge clk);
      checks++;
      if ({busy, awvalid, wd_start, wd_sel, req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err} !== 10'b0) begin
         failures++; $display("FAIL reset_ctrl got busy=%b awvalid=%b wd_start=%b wd_sel=%b exp all 0", busy, awvalid, wd_start, wd_sel);
      end
      checks++;
      if (awaddr !== 32'h0 || awlen !== 8'h0 || awid !== 4'h0) begin
         failures++; $display("FAIL reset_aw got addr=%h len=%h id=%h exp 0", awaddr, awlen, awid);
      end
      tick; rst = 0;
   endtask

   task automatic test_single;
      tick;
      req0_valid = 1; req0_addr = 32'h1000; req0_len = 8'd3;
      sb.push_back('{0, 0, 32'h1000, 8'd3});
      tick;
      for (int c = 0; c < 3; c++) begin
         awready = (c == 2);
         @(negedge clk);
         checks++;
         if (awvalid !== 1'b1 || awaddr !== 32'h1000 || awid !== 4'h1) begin
            failures++; $display("FAIL single_aw c=%0d got v=%b addr=%h id=%h exp v=1 addr=1000 id=1", c, awvalid, awaddr, awid);
         end
         checks++;
         if (req0_grant !== (c == 2)) begin
            failures++; $display("FAIL single_grant c=%0d got %b exp %0d", c, req0_grant, c == 2);
         end
         tick;
      end
      awready = 0; req0_valid = 0;
      @(negedge clk);
      checks++;
      if (wd_start !== 1'b1 || awvalid !== 1'b0 || wd_sel !== 1'b0) begin
         failures++; $display("FAIL single_wdstart got wd_start=%b awvalid=%b wd_sel=%b exp 1 0 0", wd_start, awvalid, wd_sel);
      end
      tick; finish_wd = 1;
      @(negedge clk);
      checks++;
      if (wd_start !== 1'b0) begin failures++; $display("FAIL single_wdstart_pulse got %b exp 0", wd_start); end
      tick; finish_wd = 0;
      tick; finish_wresp = 1; sb.push_back('{1, 0, 0, 0});
      @(negedge clk);
      checks++;
      if (req0_done !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL single_resp got done=%b busy=%b exp 0 1", req0_done, busy);
      end
      tick; finish_wresp = 0;
      @(negedge clk);
      checks++;
      if (req0_done !== 1'b1) begin failures++; $display("FAIL single_done got %b exp 1", req0_done); end
      tick;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req0_done !== 1'b0) begin
         failures++; $display("FAIL single_idle got busy=%b done=%b exp 0 0", busy, req0_done);
      end
   endtask

   task automatic test_back_to_back;
      bit got;
      int i;
      rst = 1;
      req0_valid = 1; req0_addr = 32'hA000; req0_len = 8'd2;
      req1_valid = 1; req1_addr = 32'hB000; req1_len = 8'd5;
      awready = 1;
      tick; rst = 0;
      for (int t = 0; t < 4; t++) begin
         i = t % 2;
         sb.push_back('{0, i, (i == 1) ? 32'hB000 : 32'hA000, (i == 1) ? 8'd5 : 8'd2});
         wait_aw(got);
         checks++;
         if (!got) begin failures++; $display("FAIL rr_timeout t=%0d got no awvalid exp awvalid", t); end
         checks++;
         if (awid !== ((i == 1) ? 4'h2 : 4'h1) || wd_sel !== i[0]) begin
            failures++; $display("FAIL rr_owner t=%0d got id=%h sel=%b exp idx %0d", t, awid, wd_sel, i);
         end
         tick;
         if (i == 0) req0_valid = 0; else req1_valid = 0;
         tick; finish_wd = 1;
         tick; finish_wd = 0; finish_wresp = 1; sb.push_back('{1, i, 0, 0});
         tick; finish_wresp = 0;
         if (t < 2) begin
            if (i == 0) req0_valid = 1; else req1_valid = 1;
         end
      end
      awready = 0;
      tick; tick;
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL rr_drain got %0d pending exp 0", sb.size()); end
   endtask

   task automatic test_same_cycle;
      bit got;
      req1_valid = 1; req1_addr = 32'h2000; req1_len = 8'd0; awready = 1;
      sb.push_back('{0, 1, 32'h2000, 8'd0});
      wait_aw(got);
      checks++;
      if (!got) begin failures++; $display("FAIL same_timeout got no awvalid exp awvalid"); end
      tick; req1_valid = 0; awready = 0;
      @(negedge clk);
      checks++;
      if (wd_start !== 1'b1 || wd_sel !== 1'b1) begin
         failures++; $display("FAIL same_wdstart got wd_start=%b wd_sel=%b exp 1 1", wd_start, wd_sel);
      end
      tick; finish_wd = 1; finish_wresp = 1; sb.push_back('{1, 1, 0, 0});
      tick; finish_wd = 0; finish_wresp = 0;
      @(negedge clk);
      checks++;
      if (req1_done !== 1'b1 || busy !== 1'b0 || wd_start !== 1'b0) begin
         failures++; $display("FAIL same_done got done=%b busy=%b wd_start=%b exp 1 0 0", req1_done, busy, wd_start);
      end
      tick;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || wd_start !== 1'b0 || req1_done !== 1'b0) begin
         failures++; $display("FAIL same_after got busy=%b wd_start=%b done=%b exp 0 0 0", busy, wd_start, req1_done);
      end
   endtask

   task automatic test_timeout;
      bit got;
      req0_valid = 1; req0_addr = 32'h3000; req0_len = 8'd7; awready = 1;
      sb.push_back('{0, 0, 32'h3000, 8'd7});
      wait_aw(got);
      checks++;
      if (!got) begin failures++; $display("FAIL tmo_aw_timeout got no awvalid exp awvalid"); end
      tick; req0_valid = 0; awready = 0;
      sb.push_back('{2, 0, 0, 0});
      for (int n = 1; n <= 8; n++) begin
         tick; finish_wd = (n == 1);
         @(negedge clk);
         checks++;
         if (n < 8) begin
            if (req0_err !== 1'b0 || busy !== 1'b1) begin
               failures++; $display("FAIL tmo_early n=%0d got err=%b busy=%b exp 0 1", n, req0_err, busy);
            end
         end else if (req0_err !== 1'b1 || busy !== 1'b0 || req0_done !== 1'b0) begin
            failures++; $display("FAIL tmo_err got err=%b busy=%b done=%b exp 1 0 0", req0_err, busy, req0_done);
         end
      end
      tick; finish_wd = 0;
      req0_valid = 1; req0_addr = 32'h4000; req0_len = 8'd1; awready = 1;
      sb.push_back('{0, 0, 32'h4000, 8'd1});
      wait_aw(got);
      checks++;
      if (!got) begin failures++; $display("FAIL tmo_next_aw got no awvalid exp awvalid"); end
      tick; req0_valid = 0; awready = 0;
      tick; finish_wd = 1; finish_wresp = 1; sb.push_back('{1, 0, 0, 0});
      tick; finish_wd = 0; finish_wresp = 0;
      @(negedge clk);
      checks++;
      if (req0_done !== 1'b1 || req0_err !== 1'b0) begin
         failures++; $display("FAIL tmo_next_done got done=%b err=%b exp 1 0", req0_done, req0_err);
      end
   endtask

   task automatic test_tmo_race;
      bit got;
      tick;
      req1_valid = 1; req1_addr = 32'h5000; req1_len = 8'd4; awready = 1;
      sb.push_back('{0, 1, 32'h5000, 8'd4});
      wait_aw(got);
      checks++;
      if (!got) begin failures++; $display("FAIL race_aw_timeout got no awvalid exp awvalid"); end
      tick; req1_valid = 0; awready = 0;
      for (int n = 1; n <= 8; n++) begin
         tick; finish_wd = (n == 1); finish_wresp = (n == 7);
         if (n == 7) sb.push_back('{1, 1, 0, 0});
         @(negedge clk);
         checks++;
         if (n < 8) begin
            if (req1_done !== 1'b0 || req1_err !== 1'b0) begin
               failures++; $display("FAIL race_early n=%0d got done=%b err=%b exp 0 0", n, req1_done, req1_err);
            end
         end else if (req1_done !== 1'b1 || req1_err !== 1'b0) begin
            failures++; $display("FAIL race_done got done=%b err=%b exp 1 0", req1_done, req1_err);
         end
      end
      tick; finish_wd = 0; finish_wresp = 0;
   endtask

   task automatic test_reset_mid;
      bit got;
      tick;
      req0_valid = 1; req0_addr = 32'h6000; req0_len = 8'd2; awready = 1;
      sb.push_back('{0, 0, 32'h6000, 8'd2});
      wait_aw(got);
      checks++;
      if (!got) begin failures++; $display("FAIL rstmid_aw_timeout got no awvalid exp awvalid"); end
      tick; req0_valid = 0; awready = 0;
      req1_valid = 1; req1_addr = 32'h7000; req1_len = 8'd6;
      tick; finish_wd = 1;
      tick; finish_wd = 0;
      tick;
      rst = 1; #1;
      checks++;
      if ({busy, awvalid, wd_start, req0_done, req0_err, req1_grant} !== 6'b0 || awaddr !== 32'h0 || awid !== 4'h0) begin
         failures++; $display("FAIL rstmid_clear got busy=%b awvalid=%b addr=%h id=%h exp all 0", busy, awvalid, awaddr, awid);
      end
      tick; tick;
      awready = 1;
      sb.push_back('{0, 1, 32'h7000, 8'd6});
      rst = 0;
      wait_aw(got);
      checks++;
      if (!got || awid !== 4'h2) begin
         failures++; $display("FAIL rstmid_regrant got aw=%b id=%h exp 1 2", got, awid);
      end
      tick; req1_valid = 0; awready = 0;
      tick; finish_wd = 1; finish_wresp = 1; sb.push_back('{1, 1, 0, 0});
      tick; finish_wd = 0; finish_wresp = 0;
      @(negedge clk);
      checks++;
      if (req1_done !== 1'b1 || req0_done !== 1'b0) begin
         failures++; $display("FAIL rstmid_done got d1=%b d0=%b exp 1 0", req1_done, req0_done);
      end
      tick; tick;
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL final_drain got %0d pending exp 0", sb.size()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_same_cycle();
      test_timeout();
      test_tmo_race();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
